// File: rtl/mul_issue_pkg.sv
// Shared constants for the multiplier issue controller: parameter defaults
// and FSM state encoding.
package mul_issue_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int TIMEOUT_CYC_DEF = 16;

   // FSM state encoding
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

endpackage : mul_issue_pkg

// File: rtl/mul_issue_ctrl_hilo_regs.sv
// Architectural HI/LO register pair. A multiplier commit writes both halves
// and takes priority over MTHI/MTLO writes.
module hilo_regs
   import mul_issue_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_commit,
   input  logic [2*DATA_W-1:0] i_product,
   input  logic                i_hi_we,
   input  logic                i_lo_we,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic [DATA_W-1:0]   o_hi,
   output logic [DATA_W-1:0]   o_lo
);

   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   // HI/LO update: product commit first, otherwise independent MTHI/MTLO writes
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_commit) begin
         r_hi <= i_product[2*DATA_W-1:DATA_W];
         r_lo <= i_product[DATA_W-1:0];
      end else begin
         if (i_hi_we) r_hi <= i_wdata;
         if (i_lo_we) r_lo <= i_wdata;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule : hilo_regs

// File: rtl/mul_issue_ctrl.sv
// EXE-stage initiator for a multi-cycle multiplier. Issues a one-cycle start
// pulse with registered operands, stalls EXE until the multiplier completes,
// then commits the product to HI/LO. A flushed op drains the multiplier and
// discards its result.
// Optional feature: define MUL_WATCHDOG_EN to add a WAIT/DRAIN watchdog that
// raises a sticky mul_timeout and returns the FSM to IDLE.
module mul_issue_ctrl
   import mul_issue_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                exe_valid,
   input  logic                exe_op_mult,
   input  logic                exe_op_multu,
   input  logic                exe_op_mthi,
   input  logic                exe_op_mtlo,
   input  logic                exe_flush,
   input  logic [DATA_W-1:0]   exe_rs,
   input  logic [DATA_W-1:0]   exe_rt,
   output logic                exe_stall,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo,
   output logic                mul_en,
   output logic                mul_signed,
   output logic [DATA_W-1:0]   mul_x,
   output logic [DATA_W-1:0]   mul_y,
   input  logic                mul_busy,
   input  logic                mul_complete,
   input  logic [2*DATA_W-1:0] mul_result,
   output logic                mul_timeout
);

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic              w_capture;
   logic              w_commit;
   logic              w_mult_op;
   logic              w_mult_req;
   logic              w_mt_ok;
   logic              w_wd_expire;
   logic              w_wd_block;
   logic              r_signed;
   logic [DATA_W-1:0] r_x;
   logic [DATA_W-1:0] r_y;

   assign w_mult_op  = exe_valid & (exe_op_mult | exe_op_multu);
   assign w_mult_req = w_mult_op & ~exe_flush;

   // Next-state, operand-capture and commit decode
   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mult_req && !mul_busy && !w_wd_block) begin
               w_state_nxt = S_ISSUE;
               w_capture   = 1'b1;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            // a flush cancels the op even if the product arrives in the same cycle
            if (exe_flush) begin
               w_state_nxt = mul_complete ? S_IDLE : S_DRAIN;
            end else if (mul_complete) begin
               w_state_nxt = S_COMMIT;
               w_commit    = 1'b1;
            end
         end
         S_COMMIT: w_state_nxt = S_IDLE;
         S_DRAIN: begin
            if (mul_complete) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_wd_expire) begin
         w_state_nxt = S_IDLE;
         w_commit    = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Operand and signedness capture when the op is accepted in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_signed <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
      end else if (w_capture) begin
         r_signed <= exe_op_mult;
         r_x      <= exe_rs;
         r_y      <= exe_rt;
      end
   end

`ifdef MUL_WATCHDOG_EN
   localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;
   logic            r_wd_abort;
   logic            w_wd_active;

   assign w_wd_active = (r_state == S_WAIT) || (r_state == S_DRAIN);
   assign w_wd_expire = w_wd_active && (r_wd_cnt == WD_LAST);

   // Watchdog: count WAIT/DRAIN cycles; on expiry flag a sticky error and
   // hold off re-issue for one cycle so the stuck instruction can retire
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd_cnt   <= '0;
         r_timeout  <= 1'b0;
         r_wd_abort <= 1'b0;
      end else begin
         r_wd_abort <= w_wd_expire;
         if (w_wd_expire) r_timeout <= 1'b1;
         if (w_wd_active && !w_wd_expire) r_wd_cnt <= r_wd_cnt + 1'b1;
         else                             r_wd_cnt <= '0;
      end
   end

   assign w_wd_block  = r_wd_abort;
   assign mul_timeout = r_timeout;
`else
   assign w_wd_expire = 1'b0;
   assign w_wd_block  = 1'b0;
   assign mul_timeout = 1'b0;
`endif

   // Stall: the EXE mult is held until COMMIT; any new mult waits out a drain
   always_comb begin
      exe_stall = 1'b0;
      case (r_state)
         S_IDLE:           exe_stall = w_mult_req & ~w_wd_block;
         S_ISSUE, S_WAIT:  exe_stall = w_mult_req;
         S_DRAIN:          exe_stall = w_mult_op;
         default:          exe_stall = 1'b0;
      endcase
   end

   assign w_mt_ok = exe_valid & ~exe_flush & (r_state == S_IDLE) & ~exe_stall;

   hilo_regs #(
      .DATA_W (DATA_W)
   ) u_hilo (
      .clk       (clk),
      .reset     (reset),
      .i_commit  (w_commit),
      .i_product (mul_result),
      .i_hi_we   (w_mt_ok & exe_op_mthi),
      .i_lo_we   (w_mt_ok & exe_op_mtlo),
      .i_wdata   (exe_rs),
      .o_hi      (hi),
      .o_lo      (lo)
   );

   assign mul_en     = (r_state == S_ISSUE);
   assign mul_signed = r_signed;
   assign mul_x      = r_x;
   assign mul_y      = r_y;

endmodule : mul_issue_ctrl

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed and random MULT/MULTU,
// busy back-pressure, MTHI/MTLO, flush/drain, reset mid-op and a stuck
// multiplier (watchdog checks under MUL_WATCHDOG_EN).
module tb_mul_issue_ctrl;

   localparam int W  = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          exe_valid, exe_op_mult, exe_op_multu, exe_op_mthi, exe_op_mtlo, exe_flush;
   logic [W-1:0]  exe_rs, exe_rt;
   logic          exe_stall;
   logic [W-1:0]  hi, lo;
   logic          mul_en, mul_signed;
   logic [W-1:0]  mul_x, mul_y;
   logic          mul_busy, mul_complete;
   logic [2*W-1:0] mul_result;
   logic          mul_timeout;

   mul_issue_ctrl #(.DATA_W(W), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .exe_valid(exe_valid), .exe_op_mult(exe_op_mult), .exe_op_multu(exe_op_multu),
      .exe_op_mthi(exe_op_mthi), .exe_op_mtlo(exe_op_mtlo), .exe_flush(exe_flush),
      .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_stall(exe_stall),
      .hi(hi), .lo(lo), .mul_en(mul_en), .mul_signed(mul_signed),
      .mul_x(mul_x), .mul_y(mul_y), .mul_busy(mul_busy), .mul_complete(mul_complete),
      .mul_result(mul_result), .mul_timeout(mul_timeout)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference product: plain 64-bit arithmetic on sign- or zero-extended operands
   function automatic logic [63:0] mul_ref(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   // Multiplier model: accepts mul_en, stays busy for mdl_lat cycles, then
   // pulses complete with the product of the operands it was handed
   logic   mdl_busy = 1'b0;
   logic   tb_busy  = 1'b0;
   int     mdl_lat  = 3;
   int     mdl_cnt  = 0;
   bit     mdl_never = 1'b0;
   bit     mdl_kill  = 1'b0;
   logic [63:0] mdl_prod;
   assign mul_busy = mdl_busy | tb_busy;

   initial begin
      mul_complete = 1'b0;
      mul_result   = '0;
      forever begin
         @(negedge clk);
         mul_complete = 1'b0;
         mul_result   = {$urandom, $urandom};
         if (mdl_kill) begin
            mdl_cnt  = 0;
            mdl_busy = 1'b0;
            mdl_kill = 1'b0;
         end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
               mdl_busy     = 1'b0;
               mul_complete = 1'b1;
               mul_result   = mdl_prod;
            end
         end else if (mul_en === 1'b1) begin
            mdl_prod = mul_ref(mul_signed, mul_x, mul_y);
            mdl_busy = 1'b1;
            if (!mdl_never) mdl_cnt = mdl_lat;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_ops();
      exe_valid = 0; exe_op_mult = 0; exe_op_multu = 0;
      exe_op_mthi = 0; exe_op_mtlo = 0; exe_flush = 0;
   endtask

   task automatic present_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      exe_valid = 1; exe_op_mult = s; exe_op_multu = ~s; exe_rs = a; exe_rt = b;
   endtask

   // Wait (bounded) for the mul_en pulse; returns with time just after sampling it
   task automatic wait_mul_en(input string tag);
      bit seen = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mul_en === 1'b1) begin seen = 1; break; end
         tick();
      end
      check({tag, "_mul_en_seen"}, seen, 1);
   endtask

   // Wait (bounded) for exe_stall to drop
   task automatic wait_retire(input string tag);
      bit done = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (exe_stall !== 1'b1) begin done = 1; break; end
         tick();
      end
      check({tag, "_retired"}, done, 1);
   endtask

   // Full MULT/MULTU transaction with optional busy back-pressure cycles
   task automatic do_mul(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input int busy_cyc);
      int n_stall = 0;
      int n_en    = 0;
      bit done    = 0;
      logic [63:0] p;
      p = mul_ref(s, a, b);
      mdl_lat = lat;
      present_mul(s, a, b);
      for (int c = 0; c < 60; c++) begin
         tb_busy = (c < busy_cyc);
         #1;
         if (mul_en === 1'b1) begin
            n_en++;
            check({tag, "_signed"}, mul_signed, s);
            check({tag, "_x"}, mul_x, a);
            check({tag, "_y"}, mul_y, b);
         end
         if (exe_stall !== 1'b1) begin done = 1; break; end
         n_stall++;
         tick();
      end
      tb_busy = 0;
      check({tag, "_done"}, done, 1);
      check({tag, "_stall_cycles"}, n_stall, busy_cyc + lat + 2);
      check({tag, "_en_pulses"}, n_en, 1);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      clear_ops();
      tick();
   endtask

   task automatic mt_write(input string tag, input logic whi, input logic wlo, input logic [W-1:0] d);
      exe_valid = 1; exe_op_mthi = whi; exe_op_mtlo = wlo; exe_rs = d;
      #1;
      check({tag, "_stall"}, exe_stall, 0);
      tick();
      clear_ops();
      if (whi) exp_hi = d;
      if (wlo) exp_lo = d;
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [W-1:0] a, b;
      logic [W-1:0] old_hi, old_lo;
      logic         s;
      bit           en_seen;

      reset = 1; clear_ops(); exe_rs = '0; exe_rt = '0;
      #3;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_mul_en", mul_en, 0);
      check("rst_signed", mul_signed, 0);
      check("rst_x", mul_x, 0);
      check("rst_y", mul_y, 0);
      check("rst_timeout", mul_timeout, 0);
      check("rst_stall", exe_stall, 0);
      tick();
      reset = 0;
      tick();

      // Directed vectors
      do_mul("mult_neg", 1'b1, 32'hFFFF_FFFE, 32'd3, 3, 0);
      check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo_const", lo, 32'hFFFF_FFFA);
      do_mul("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0);
      check("multu_hi_const", hi, 32'hFFFF_FFFE);
      check("multu_lo_const", lo, 32'h0000_0001);
      do_mul("mult_busy", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2, 3);

      // Random operands, signedness, latency and back-pressure
      for (int i = 0; i < 8; i++) begin
         do_mul("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom,
                int'($urandom_range(1, 5)), int'($urandom_range(0, 2)));
      end

      // MTHI/MTLO
      mt_write("mthi", 1'b1, 1'b0, 32'h0000_1234);
      mt_write("mtlo", 1'b0, 1'b1, 32'h0000_ABCD);
      check("mthi_const", hi, 32'h0000_1234);
      check("mtlo_const", lo, 32'h0000_ABCD);
      mt_write("mt_both", 1'b1, 1'b1, $urandom);

      // MTHI flagged while a mult is stalled on busy: no write
      tb_busy = 1; exe_valid = 1; exe_op_mult = 1; exe_op_mthi = 1; exe_rs = 32'hDEAD_BEEF;
      #1;
      check("mt_stalled_stall", exe_stall, 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("mt_stalled_hi", hi, exp_hi);
      end
      clear_ops();
      tb_busy = 0;
      tick();

      // Flush one cycle after mul_en: drain, discard, then a new MULTU issues
      mdl_lat = 3;
      old_hi = exp_hi; old_lo = exp_lo;
      present_mul(1'b1, 32'd5, 32'd7);
      wait_mul_en("flush");
      tick();
      exe_flush = 1;
      tick();
      exe_flush = 0;
      a = $urandom; b = $urandom;
      present_mul(1'b0, a, b);
      en_seen = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (mul_en === 1'b1) begin en_seen = 1; break; end
         check("drain_stall", exe_stall, 1);
         tick();
      end
      check("drain_reissue", en_seen, 1);
      check("drain_hi_kept", hi, old_hi);
      check("drain_lo_kept", lo, old_lo);
      check("drain_new_signed", mul_signed, 0);
      check("drain_new_x", mul_x, a);
      tick();
      wait_retire("drain_new");
      exp_hi = mul_ref(1'b0, a, b) >> 32;
      exp_lo = 32'(mul_ref(1'b0, a, b));
      check("drain_new_hi", hi, exp_hi);
      check("drain_new_lo", lo, exp_lo);
      clear_ops();
      tick();

      // Flush coinciding with complete: straight to IDLE, no commit
      mdl_lat = 3;
      present_mul(1'b1, $urandom, $urandom);
      wait_mul_en("flcmp");
      tick(); tick(); tick();
      exe_flush = 1;
      tick();
      clear_ops();
      #1;
      check("flcmp_stall", exe_stall, 0);
      check("flcmp_hi", hi, exp_hi);
      check("flcmp_lo", lo, exp_lo);
      mt_write("flcmp_idle_mthi", 1'b1, 1'b0, $urandom);

      // Reset in WAIT, then a late complete from the multiplier
      mdl_lat = 5;
      present_mul(1'b0, $urandom, $urandom);
      wait_mul_en("rstw");
      tick();
      clear_ops();
      #1;
      reset = 1;
      #1;
      check("rstw_hi", hi, 0);
      check("rstw_lo", lo, 0);
      check("rstw_mul_en", mul_en, 0);
      check("rstw_x", mul_x, 0);
      check("rstw_y", mul_y, 0);
      check("rstw_signed", mul_signed, 0);
      check("rstw_stall", exe_stall, 0);
      tick();
      reset = 0;
      exp_hi = '0; exp_lo = '0;
      en_seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (mul_en !== 1'b0 || exe_stall !== 1'b0) en_seen = 1;
      end
      check("rstw_quiet", en_seen, 0);
      check("rstw_late_hi", hi, 0);
      check("rstw_late_lo", lo, 0);

      // Multiplier that never completes
      mdl_never = 1;
      mt_write("stuck_pre", 1'b1, 1'b1, $urandom);
      present_mul(1'b1, $urandom, $urandom);
      wait_mul_en("stuck");
`ifdef MUL_WATCHDOG_EN
      for (int c = 0; c < TO; c++) begin
         tick();
         check("wd_wait_stall", exe_stall, 1);
         check("wd_wait_timeout", mul_timeout, 0);
      end
      tick();
      check("wd_timeout", mul_timeout, 1);
      check("wd_stall_release", exe_stall, 0);
      check("wd_mul_en", mul_en, 0);
      check("wd_hi", hi, exp_hi);
      check("wd_lo", lo, exp_lo);
      clear_ops();
      tick();
      check("wd_sticky", mul_timeout, 1);
`else
      for (int c = 0; c < 40; c++) begin
         tick();
         check("hold_stall", exe_stall, 1);
         check("hold_timeout", mul_timeout, 0);
      end
      check("hold_hi", hi, exp_hi);
      clear_ops();
`endif
      mdl_kill = 1;
      tick();
      reset = 1;
      tick();
      reset = 0;
      mdl_never = 0;
      tick();
      check("final_timeout", mul_timeout, 0);
      check("final_hi", hi, 0);
      s = 1'b1;
      do_mul("final_mult", s, 32'd12345, 32'hFFFF_FFF9, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_mul_issue_ctrl
